// File: rtl/mult_div_if.sv
// Request/response bundle between the multicycle control path and mult_div_unit.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, operand_a, operand_b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle MIPS HI/LO unit: shift-add multiply and restoring divide, one bit per clock.
// Define MULTDIV_UNSIGNED_EN to make op 2/3 (MULTU/DIVU) unsigned; otherwise op[1] is ignored.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     operand;
  logic                 is_div;
  logic                 neg_res;
  logic                 neg_rem;
  logic                 dz;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 div_zero_r;

  logic                 is_signed;
`ifdef MULTDIV_UNSIGNED_EN
  assign is_signed = ~bus.op[1];
`else
  logic unused_op_hi;
  assign is_signed    = 1'b1;
  assign unused_op_hi = bus.op[1];
`endif

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  assign a_neg = is_signed & bus.operand_a[WIDTH-1];
  assign b_neg = is_signed & bus.operand_b[WIDTH-1];
  assign a_mag = a_neg ? -bus.operand_a : bus.operand_a;
  assign b_mag = b_neg ? -bus.operand_b : bus.operand_b;

  // Multiply: upper half accumulates, multiplier bits drain out of the bottom.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};

  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  logic [WIDTH:0] div_trial;
  logic [WIDTH:0] div_diff;
  logic           div_ge;
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, operand};
  assign div_ge    = ~div_diff[WIDTH];

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  assign prod_fixed = neg_res ? -acc : acc;
  assign quot_fixed = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fixed  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      operand    <= '0;
      is_div     <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      dz         <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt     <= '0;
            busy_r  <= 1'b1;
            is_div  <= bus.op[0];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (bus.op[0]) begin
              acc     <= {{WIDTH{1'b0}}, a_mag};
              operand <= b_mag;
              // A zero divisor skips the iterations and only reports the exception.
              if (bus.operand_b == '0) begin
                dz    <= 1'b1;
                state <= FIX;
              end else begin
                dz    <= 1'b0;
                state <= DIV;
              end
            end else begin
              acc     <= {{WIDTH{1'b0}}, b_mag};
              operand <= a_mag;
              dz      <= 1'b0;
              state   <= MULT;
            end
          end
        end
        MULT: begin
          acc <= acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        DIV: begin
          acc <= {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (dz) begin
            div_zero_r <= 1'b1;
          end else if (is_div) begin
            hi_r <= rem_fixed;
            lo_r <= quot_fixed;
          end else begin
            hi_r <= prod_fixed[2*WIDTH-1:WIDTH];
            lo_r <= prod_fixed[WIDTH-1:0];
          end
          dz     <= 1'b0;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/latency queued at start, compared at done.
module tb_mult_div_unit;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  mult_div_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  // Independent arithmetic reference using 64-bit native operators.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic        sgn;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sgn = 1'b1;
`ifdef MULTDIV_UNSIGNED_EN
    sgn = ~op[1];
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    e.dz  = 1'b0;
    e.lat = 33;
    if (!op[0]) begin
      p    = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi  = model_hi;
      e.lo  = model_lo;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      p    = sa / sb;
      e.lo = p[31:0];
      p    = sa % sb;
      e.hi = p[31:0];
    end
    return e;
  endfunction

  // Caller is at a negedge; start is sampled at the next rising edge, then operands are scrambled.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.operand_a = ~a;
    bus.operand_b = b + 32'd1;
  endtask

  task automatic wait_done(input int inject_at, input int limit, output int cycles, output logic timed_out);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < limit) begin
      if (cycles == inject_at) begin
        bus.start     = 1'b1;
        bus.op        = 2'd0;
        bus.operand_a = 32'h0000_1234;
        bus.operand_b = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    bus.start = 1'b0;
    timed_out = (bus.done !== 1'b1);
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = 2'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero} !== 67'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b want all zero",
               bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    exp_t e;
    int   cyc;
    logic to;
    launch(2'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    sb_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA, dz: 1'b0, lat: 33});
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mult_busy_start: got %b want 1", bus.busy);
    end
    wait_done(-1, 100, cyc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || cyc != e.lat) begin
      errors++;
      $display("[TB] FAIL mult_latency: got %0d (timeout=%b) want %0d", cyc, to, e.lat);
    end
    checks++;
    if ({bus.hi, bus.lo, bus.div_zero, bus.busy} !== {e.hi, e.lo, e.dz, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mult_result: got hi=%h lo=%h dz=%b busy=%b want hi=%h lo=%h dz=%b busy=0",
               bus.hi, bus.lo, bus.div_zero, bus.busy, e.hi, e.lo, e.dz);
    end
    model_hi = e.hi;
    model_lo = e.lo;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mult_done_pulse: got done=%b want 0 one cycle later", bus.done);
    end
  endtask

  task automatic test_reset_mid_mult();
    exp_t e;
    int   cyc;
    logic to;
    launch(2'd0, 32'h0001_2345, 32'h0006_789A);
    repeat (9) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_busy_before: got %b want 1", bus.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'd0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: got hi=%h lo=%h busy=%b done=%b want all zero",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    launch(2'd0, 32'd3, 32'd5);
    sb_q.push_back('{hi: 32'd0, lo: 32'd15, dz: 1'b0, lat: 33});
    wait_done(-1, 100, cyc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || cyc != e.lat || {bus.hi, bus.lo} !== {e.hi, e.lo}) begin
      errors++;
      $display("[TB] FAIL midreset_next_op: got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
               bus.hi, bus.lo, cyc, e.hi, e.lo, e.lat);
    end
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  task automatic test_div_ignore_start();
    exp_t e;
    int   cyc;
    logic to;
    @(negedge clk);
    launch(2'd1, 32'hFFFF_FFF9, 32'd2);
    sb_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dz: 1'b0, lat: 33});
    wait_done(4, 100, cyc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || cyc != e.lat) begin
      errors++;
      $display("[TB] FAIL div_latency: got %0d (timeout=%b) want %0d", cyc, to, e.lat);
    end
    checks++;
    if ({bus.hi, bus.lo, bus.div_zero} !== {e.hi, e.lo, e.dz}) begin
      errors++;
      $display("[TB] FAIL div_neg_result: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
               bus.hi, bus.lo, bus.div_zero, e.hi, e.lo, e.dz);
    end
    model_hi = e.hi;
    model_lo = e.lo;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL div_ignored_start: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    int   cyc;
    logic to;
    launch(2'd1, 32'h0000_0451, 32'h0000_0020);
    sb_q.push_back('{hi: 32'h11, lo: 32'h22, dz: 1'b0, lat: 33});
    wait_done(-1, 100, cyc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || {bus.hi, bus.lo} !== {e.hi, e.lo}) begin
      errors++;
      $display("[TB] FAIL divzero_setup: got hi=%h lo=%h want hi=%h lo=%h", bus.hi, bus.lo, e.hi, e.lo);
    end
    model_hi = e.hi;
    model_lo = e.lo;
    @(negedge clk);
    launch(2'd1, 32'd100, 32'd0);
    sb_q.push_back('{hi: 32'h11, lo: 32'h22, dz: 1'b1, lat: 1});
    wait_done(-1, 100, cyc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || cyc != e.lat) begin
      errors++;
      $display("[TB] FAIL divzero_latency: got %0d (timeout=%b) want %0d", cyc, to, e.lat);
    end
    checks++;
    if ({bus.hi, bus.lo, bus.div_zero, bus.busy} !== {e.hi, e.lo, e.dz, 1'b0}) begin
      errors++;
      $display("[TB] FAIL divzero_result: got hi=%h lo=%h dz=%b busy=%b want hi=%h lo=%h dz=1 busy=0",
               bus.hi, bus.lo, bus.div_zero, bus.busy, e.hi, e.lo);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL divzero_pulse: got done=%b dz=%b want 0 0", bus.done, bus.div_zero);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    logic to;
    launch(2'd1, 32'h8000_0000, 32'hFFFF_FFFF);
    sb_q.push_back('{hi: 32'd0, lo: 32'h8000_0000, dz: 1'b0, lat: 33});
    wait_done(-1, 100, cyc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || {bus.hi, bus.lo, bus.div_zero} !== {e.hi, e.lo, e.dz}) begin
      errors++;
      $display("[TB] FAIL b2b_div_overflow: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=0",
               bus.hi, bus.lo, bus.div_zero, e.hi, e.lo);
    end
    launch(2'd0, 32'd7, 32'd6);
    sb_q.push_back('{hi: 32'd0, lo: 32'd42, dz: 1'b0, lat: 33});
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got busy=%b want 1", bus.busy);
    end
    wait_done(-1, 100, cyc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || cyc != e.lat || {bus.hi, bus.lo} !== {e.hi, e.lo}) begin
      errors++;
      $display("[TB] FAIL b2b_mult: got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
               bus.hi, bus.lo, cyc, e.hi, e.lo, e.lat);
    end
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  task automatic test_unsigned();
    exp_t e;
    int   cyc;
    logic to;
    @(negedge clk);
    launch(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef MULTDIV_UNSIGNED_EN
    sb_q.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dz: 1'b0, lat: 33});
`else
    sb_q.push_back('{hi: 32'h0000_0000, lo: 32'h0000_0001, dz: 1'b0, lat: 33});
`endif
    wait_done(-1, 100, cyc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || cyc != e.lat || {bus.hi, bus.lo} !== {e.hi, e.lo}) begin
      errors++;
      $display("[TB] FAIL multu: got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
               bus.hi, bus.lo, cyc, e.hi, e.lo, e.lat);
    end
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  task automatic test_random();
    exp_t        e;
    int          cyc;
    logic        to;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i == 7) a = 32'h8000_0000;
      launch(op, a, b);
      sb_q.push_back(model(op, a, b));
      wait_done(-1, 100, cyc, to);
      e = sb_q.pop_front();
      checks++;
      if (to || cyc != e.lat || {bus.hi, bus.lo, bus.div_zero} !== {e.hi, e.lo, e.dz}) begin
        errors++;
        $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got hi=%h lo=%h dz=%b lat=%0d want hi=%h lo=%h dz=%b lat=%0d",
                 i, op, a, b, bus.hi, bus.lo, bus.div_zero, cyc, e.hi, e.lo, e.dz, e.lat);
      end
      model_hi = e.hi;
      model_lo = e.lo;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_reset_mid_mult();
    test_div_ignore_start();
    test_div_zero();
    test_back_to_back();
    test_unsigned();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle multiply/divide unit in the execute stage of the multicycle MIPS datapath.
- Consumes the A-register value (operand_a) and the ALU source-B mux output (operand_b), the same operand path that feeds the ALU.
- Produces the HI/LO register contents for MULT/DIV and MFHI/MFLO.
- The control FSM pulses start and stalls until done.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  0=MULT, 1=DIV, 2=MULTU, 3=DIVU (2/3 see Optional Feature).
- operand_a  input  WIDTH  multiplicand / dividend (rs).
- operand_b  input  WIDTH  multiplier / divisor (from ALU source-B mux).
- hi  output  WIDTH  product high word / remainder.
- lo  output  WIDTH  product low word / quotient.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  one-cycle pulse with done when a divide has divisor 0.

Behaviour:
- Reset (asynchronous, active-high):
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - Counter=0, state=IDLE.
  - Applies mid-operation; the in-flight result is discarded.
- States: IDLE, MULT, DIV, FIX.
- IDLE:
  - On start=1 at a rising edge (edge E0), latch op, operand_a and operand_b. Later operand changes are ignored.
  - Convert signed operands to magnitudes and record result signs.
  - Clear counter, set busy=1.
  - Go to MULT (op 0/2) or DIV (op 1/3).
- MULT: shift-add, one multiplier bit per edge, 64-bit accumulator. After 32 iterations (E1..E32), go to FIX.
- DIV: restoring division, one quotient bit per edge. After 32 iterations (E1..E32), go to FIX.
- Divide by zero:
  - At E0, a DIV/DIVU with operand_b==0 goes straight to FIX with no iterations.
  - FIX then pulses done=1 and div_zero=1 at E1. hi and lo are left unchanged.
- FIX (E33 for normal operations):
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Load hi/lo, pulse done=1, busy=0, return to IDLE.
- Total latency for normal operations: done is high in the cycle after the 33rd rising edge following E0. hi/lo update on the same edge that raises done.
- busy stays high from after E0 until the edge that raises done. done and div_zero are high for exactly one cycle.
- start while busy is ignored (not queued). start in the cycle where done=1 is accepted, since the FSM is back in IDLE.
- Arithmetic:
  - MULT: {hi,lo} is the exact 64-bit two's-complement product.
  - DIV: quotient truncates toward zero.
  - Boundary 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0, no exception flag.
- hi/lo hold their value until the next completed operation.

Optional Feature:
- Macro: MULTDIV_UNSIGNED_EN.
- Defined: op 2 (MULTU) and op 3 (DIVU) treat both operands as unsigned; FIX applies no sign correction.
- Undefined: op[1] is ignored; op 2 behaves as MULT and op 3 as DIV (signed). Port list and latency are unchanged.

Test Plan:
- Reset mid-MULT: assert reset 10 cycles after start -> hi=0, lo=0, busy=0, done=0 immediately. The next start completes normally.
- MULT 0xFFFFFFFE * 0x00000003 -> done 33 edges after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy low the same cycle.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). A start pulse at cycle 5 during the operation is ignored.
- DIV 100 / 0 with prior hi=0x11, lo=0x22 -> done and div_zero high one edge after start; hi=0x11, lo=0x22 retained.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Back-to-back start in the done cycle with MULT 7*6 -> lo=42, hi=0.
- With MULTDIV_UNSIGNED_EN: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Without the macro: same stimulus -> hi=0, lo=1.
